bottle_counter: RTL and testbench
=================================

Name: bottle_counter

Overview:
- Counts filled bottles passing the conveyor exit sensor and packs them into dozens.
- Drives a 13-bit binary total directly into the binary-to-BCD/7-segment display stage, which shows the two low decimal digits.
- Provides sensor debouncing, per-dozen pulse for the capping/boxing controller, saturation at a configurable limit, and a synchronous clear.

Parameters:
- DEBOUNCE_CYCLES, 1000: number of consecutive stable clk cycles required to accept a sensor level change; must be >= 2.
- DOZEN_SIZE, 12: bottles per box.
- MAX_COUNT, 99: saturation value of bottle_total; must be <= 8191.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- sensor_raw  input  1  unsynchronised bottle-present sensor, high while a bottle blocks it
- count_en  input  1  counting enabled (line running)
- clear  input  1  synchronous clear of counts, active-high
- bottle_total  output  13  binary bottle count to display stage
- dozen_count  output  13  completed boxes
- in_box  output  4  bottles in current box, 0..DOZEN_SIZE-1
- dozen_done  output  1  one-cycle pulse when a box completes
- full  output  1  high while bottle_total == MAX_COUNT

Behaviour:
- Reset: one clock domain; reset is synchronous and active-high on rst. On rst, all outputs are 0, the synchronizer flops are 0, the debounce counter is 0, and the FSM is S_LOW.
- Input sync: sensor_raw passes through a 2-flop synchronizer. Downstream logic uses only the synchronised value s.
- Debounce FSM, four states:
  - S_LOW: if s == 1, clear the debounce counter and go to S_RISE.
  - S_RISE: if s == 0, go to S_LOW. Otherwise increment the counter. When it reaches DEBOUNCE_CYCLES-1, go to S_HIGH and assert internal accept for exactly that cycle.
  - S_HIGH: if s == 0, clear the counter and go to S_FALL.
  - S_FALL: if s == 1, go to S_HIGH. Otherwise increment. At DEBOUNCE_CYCLES-1, go to S_LOW.
  - Exactly one accept per debounced rising edge. Glitches shorter than DEBOUNCE_CYCLES never count.
  - Latency from the first sample of sensor_raw = 1 to the count update: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
- Counting on the cycle after accept, if count_en == 1 and full == 0:
  - bottle_total += 1
  - in_box += 1
  - If in_box was DOZEN_SIZE-1: in_box <= 0, dozen_count += 1, and dozen_done = 1 for that one cycle.
- If count_en == 0 or full == 1 when accept fires, the bottle is dropped. It is not queued for later.
- Saturation:
  - full = (bottle_total == MAX_COUNT), registered alongside bottle_total.
  - bottle_total never exceeds MAX_COUNT.
  - dozen_count saturates at 8191.
- clear:
  - Zeroes bottle_total, dozen_count, in_box, dozen_done and full on the next edge.
  - Does not touch the debounce FSM.
  - clear has priority over a simultaneous accept; that bottle is lost.
- rst has priority over clear. rst mid-debounce abandons the pending edge.
- A sensor held high permanently yields one count only.
- Width rules: all arithmetic is unsigned. The debounce counter is $clog2(DEBOUNCE_CYCLES) bits wide. No wrap-around is permitted on any output.

Decomposition:
- Shared package bottle_pkg holds:
  - the debounce state enum: S_LOW, S_RISE, S_HIGH, S_FALL
  - COUNT_W = 13, the display data width
  - default DOZEN_SIZE and MAX_COUNT
- Sub-module debounce_edge holds the synchronizer, the FSM and the accept pulse. It is reused later for the start/stop push-buttons.
- bottle_counter instantiates debounce_edge and adds the counting and saturation logic.

Test Plan (use DEBOUNCE_CYCLES = 4 for simulation speed):
- Reset: assert rst for 3 cycles while sensor_raw = 1 -> all outputs 0; after release, exactly one count once debounce completes.
- Glitch rejection: sensor_raw high for 2 cycles, then low -> bottle_total stays 0, no accept.
- Clean pulses: 13 pulses, each high 10 / low 10 cycles, count_en = 1 -> bottle_total = 13, dozen_count = 1, in_box = 1, dozen_done pulsed exactly once (on the 12th bottle), 1 cycle wide.
- Saturation: MAX_COUNT = 5, 7 pulses -> bottle_total = 5, full = 1, in_box = 5, dozen_count = 0.
- Gating and clear: count_en = 0 during 3 pulses -> no change. Then clear asserted on the same cycle as an accept -> all counts 0, and the next pulse gives bottle_total = 1.
- Bounce on release: sensor high 10 cycles, then toggling 1-0-1-0 for 6 cycles, then low -> exactly 1 count.

Source files
------------

// File: rtl/bottle_pkg.sv
// Shared types and constants for the bottle counting line.
package bottle_pkg;

    // Width of the binary count handed to the BCD/7-segment display stage
    localparam int unsigned COUNT_W        = 13;
    // Width of the in-box bottle counter (supports boxes of up to 16)
    localparam int unsigned BOX_W          = 4;
    // Default box size and saturation limit
    localparam int unsigned DOZEN_SIZE_DEF = 12;
    localparam int unsigned MAX_COUNT_DEF  = 99;

    // Debounce FSM states
    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_RISE = 2'd1,
        S_HIGH = 2'd2,
        S_FALL = 2'd3
    } deb_state_e;

endpackage

// File: rtl/debounce_edge.sv
// Synchronises a raw level input, debounces it and emits one accept pulse
// per debounced rising edge.
module debounce_edge
    import bottle_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_raw,
    output logic accept
);

    localparam int unsigned CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    deb_state_e       state_q;
    deb_state_e       state_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             cnt_at_last;
    logic             accept_nxt;

    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign cnt_at_last = (cnt_inc == CNT_LAST);

    // Two-flop synchroniser; only sync_q2 is used downstream
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= sig_raw;
            sync_q2 <= sync_q1;
        end
    end

    // State register, stable-time counter and registered accept pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
            accept  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            accept  <= accept_nxt;
        end
    end

    // Next-state: a level change is accepted after DEBOUNCE_CYCLES stable samples
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_LOW: begin
                if (sync_q2) begin
                    state_nxt = S_RISE;
                end
            end
            S_RISE: begin
                if (!sync_q2) begin
                    state_nxt = S_LOW;
                end else if (cnt_at_last) begin
                    state_nxt = S_HIGH;
                end
            end
            S_HIGH: begin
                if (!sync_q2) begin
                    state_nxt = S_FALL;
                end
            end
            S_FALL: begin
                if (sync_q2) begin
                    state_nxt = S_HIGH;
                end else if (cnt_at_last) begin
                    state_nxt = S_LOW;
                end
            end
            default: state_nxt = S_LOW;
        endcase
    end

    // Counter update and accept generation; accept only on the rise commit
    always_comb begin
        cnt_nxt    = cnt_q;
        accept_nxt = 1'b0;
        case (state_q)
            S_LOW: begin
                if (sync_q2) begin
                    cnt_nxt = '0;
                end
            end
            S_RISE: begin
                if (sync_q2) begin
                    cnt_nxt    = cnt_inc;
                    accept_nxt = cnt_at_last;
                end
            end
            S_HIGH: begin
                if (!sync_q2) begin
                    cnt_nxt = '0;
                end
            end
            S_FALL: begin
                if (!sync_q2) begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: cnt_nxt = '0;
        endcase
    end

endmodule

// File: rtl/bottle_counter.sv
// Counts debounced bottles at the conveyor exit and packs them into boxes.
module bottle_counter
    import bottle_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned DOZEN_SIZE      = DOZEN_SIZE_DEF,
    parameter int unsigned MAX_COUNT       = MAX_COUNT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sensor_raw,
    input  logic               count_en,
    input  logic               clear,
    output logic [COUNT_W-1:0] bottle_total,
    output logic [COUNT_W-1:0] dozen_count,
    output logic [BOX_W-1:0]   in_box,
    output logic               dozen_done,
    output logic               full
);

    localparam logic [COUNT_W-1:0] TOTAL_MAX = COUNT_W'(MAX_COUNT);
    localparam logic [COUNT_W-1:0] DOZEN_MAX = {COUNT_W{1'b1}};
    localparam logic [BOX_W-1:0]   BOX_LAST  = BOX_W'(DOZEN_SIZE - 1);

    logic               accept;
    logic               take;
    logic               box_wrap;
    logic [COUNT_W-1:0] total_inc;

    debounce_edge #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .sig_raw (sensor_raw),
        .accept  (accept)
    );

    // A bottle is taken only while the line runs and the total has headroom
    assign take      = accept && count_en && !full && (bottle_total < TOTAL_MAX);
    assign box_wrap  = (in_box == BOX_LAST);
    assign total_inc = bottle_total + COUNT_W'(1);

    // Count, box and saturation registers; clear wins over a coincident accept
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            bottle_total <= '0;
            dozen_count  <= '0;
            in_box       <= '0;
            dozen_done   <= 1'b0;
            full         <= 1'b0;
        end else begin
            dozen_done <= 1'b0;
            if (take) begin
                bottle_total <= total_inc;
                full         <= (total_inc == TOTAL_MAX);
                if (box_wrap) begin
                    in_box     <= '0;
                    dozen_done <= 1'b1;
                    if (dozen_count != DOZEN_MAX) begin
                        dozen_count <= dozen_count + COUNT_W'(1);
                    end
                end else begin
                    in_box <= in_box + BOX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bottle_counter.sv
// Self-checking bench for bottle_counter with a scoreboard of expected counts.
module tb_bottle_counter;

    localparam int unsigned DC = 4;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        sensor_raw = 1'b0;
    logic        sensor_sat = 1'b0;
    logic        count_en   = 1'b1;
    logic        clear      = 1'b0;

    logic [12:0] bottle_total, dozen_count;
    logic [3:0]  in_box;
    logic        dozen_done, full;

    logic [12:0] sat_total, sat_dozen;
    logic [3:0]  sat_in_box;
    logic        sat_done, sat_full;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [12:0] total;
        logic [12:0] dozens;
        logic [3:0]  in_box;
        logic        done;
        logic        full;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    logic [12:0] prev_total = '0;
    int          done_cycles = 0;
    int          m_total = 0;
    int          m_dozen = 0;
    int          m_inbox = 0;

    bottle_counter #(.DEBOUNCE_CYCLES(DC), .DOZEN_SIZE(12), .MAX_COUNT(99)) dut (
        .clk(clk), .rst(rst), .sensor_raw(sensor_raw), .count_en(count_en), .clear(clear),
        .bottle_total(bottle_total), .dozen_count(dozen_count), .in_box(in_box),
        .dozen_done(dozen_done), .full(full)
    );

    bottle_counter #(.DEBOUNCE_CYCLES(DC), .DOZEN_SIZE(12), .MAX_COUNT(5)) dut_sat (
        .clk(clk), .rst(rst), .sensor_raw(sensor_sat), .count_en(count_en), .clear(clear),
        .bottle_total(sat_total), .dozen_count(sat_dozen), .in_box(sat_in_box),
        .dozen_done(sat_done), .full(sat_full)
    );

    always #5 clk = ~clk;

    // Model of one accepted bottle on the main instance; pushes the expected outputs
    function automatic void model_count();
        exp_t e;
        e.done = 1'b0;
        if (m_total < 99) begin
            m_total++;
            m_inbox++;
            if (m_inbox == 12) begin
                m_inbox = 0;
                if (m_dozen < 8191) m_dozen++;
                e.done = 1'b1;
            end
        end
        e.total  = 13'(m_total);
        e.dozens = 13'(m_dozen);
        e.in_box = 4'(m_inbox);
        e.full   = (m_total == 99);
        sbq.push_back(e);
    endfunction

    function automatic void model_clear();
        m_total = 0;
        m_dozen = 0;
        m_inbox = 0;
    endfunction

    // Scoreboard monitor: every increment of bottle_total must match the next expected entry
    always @(negedge clk) begin
        if (!rst) begin
            if (dozen_done) done_cycles++;
            if (bottle_total !== prev_total && bottle_total !== 13'd0) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected total=%0d required no change from %0d", bottle_total, prev_total);
                end else begin
                    mon_e = sbq.pop_front();
                    if (bottle_total !== mon_e.total || dozen_count !== mon_e.dozens ||
                        in_box !== mon_e.in_box || dozen_done !== mon_e.done || full !== mon_e.full) begin
                        errors++;
                        $display("FAIL sb_count got t=%0d d=%0d b=%0d dd=%0b f=%0b required t=%0d d=%0d b=%0d dd=%0b f=%0b",
                                 bottle_total, dozen_count, in_box, dozen_done, full,
                                 mon_e.total, mon_e.dozens, mon_e.in_box, mon_e.done, mon_e.full);
                    end
                end
            end
        end
        prev_total = bottle_total;
    end

    task automatic pulse(input bit on_sat, input int hi, input int lo);
        if (on_sat) sensor_sat = 1'b1; else sensor_raw = 1'b1;
        repeat (hi) @(negedge clk);
        if (on_sat) sensor_sat = 1'b0; else sensor_raw = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sbq.size() == 0) break;
            @(negedge clk);
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout pending=%0d required 0", name, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        sensor_raw = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bottle_total, dozen_count, in_box, dozen_done, full} !== 32'd0) begin
            errors++;
            $display("FAIL reset_main got t=%0d d=%0d b=%0d dd=%0b f=%0b required all 0",
                     bottle_total, dozen_count, in_box, dozen_done, full);
        end
        checks++;
        if ({sat_total, sat_dozen, sat_in_box, sat_done, sat_full} !== 32'd0) begin
            errors++;
            $display("FAIL reset_sat got t=%0d f=%0b required all 0", sat_total, sat_full);
        end
        model_count();
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (bottle_total !== 13'd0) begin
            errors++;
            $display("FAIL reset_latency_early got %0d required 0", bottle_total);
        end
        @(negedge clk);
        checks++;
        if (bottle_total !== 13'd1) begin
            errors++;
            $display("FAIL reset_latency got %0d required 1", bottle_total);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (bottle_total !== 13'd1) begin
            errors++;
            $display("FAIL held_high got %0d required 1", bottle_total);
        end
        sensor_raw = 1'b0;
        repeat (10) @(negedge clk);
        drain("reset", 5);
    endtask

    task automatic test_glitch();
        pulse(1'b0, 2, 12);
        checks++;
        if (bottle_total !== 13'd1) begin
            errors++;
            $display("FAIL glitch got %0d required 1", bottle_total);
        end
    endtask

    task automatic test_clean_pulses();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_clear();
        checks++;
        if ({bottle_total, dozen_count, in_box, dozen_done, full} !== 32'd0) begin
            errors++;
            $display("FAIL clear_idle got t=%0d d=%0d b=%0d required all 0", bottle_total, dozen_count, in_box);
        end
        done_cycles = 0;
        for (int i = 0; i < 13; i++) begin
            model_count();
            pulse(1'b0, 10, 10);
        end
        drain("clean", 40);
        checks++;
        if (bottle_total !== 13'd13 || dozen_count !== 13'd1 || in_box !== 4'd1) begin
            errors++;
            $display("FAIL clean_final got t=%0d d=%0d b=%0d required t=13 d=1 b=1",
                     bottle_total, dozen_count, in_box);
        end
        checks++;
        if (done_cycles != 1) begin
            errors++;
            $display("FAIL dozen_done_width got %0d high cycles required 1", done_cycles);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) pulse(1'b1, 10, 10);
        checks++;
        if (sat_total !== 13'd4 || sat_full !== 1'b0) begin
            errors++;
            $display("FAIL sat_below got t=%0d f=%0b required t=4 f=0", sat_total, sat_full);
        end
        for (int i = 0; i < 3; i++) pulse(1'b1, 10, 10);
        checks++;
        if (sat_total !== 13'd5 || sat_full !== 1'b1 || sat_in_box !== 4'd5 || sat_dozen !== 13'd0) begin
            errors++;
            $display("FAIL sat_final got t=%0d f=%0b b=%0d d=%0d required t=5 f=1 b=5 d=0",
                     sat_total, sat_full, sat_in_box, sat_dozen);
        end
    endtask

    task automatic test_gating_clear();
        count_en = 1'b0;
        for (int i = 0; i < 3; i++) pulse(1'b0, 10, 10);
        checks++;
        if (bottle_total !== 13'd13 || dozen_count !== 13'd1 || in_box !== 4'd1) begin
            errors++;
            $display("FAIL gated got t=%0d d=%0d b=%0d required t=13 d=1 b=1", bottle_total, dozen_count, in_box);
        end
        count_en   = 1'b1;
        sensor_raw = 1'b1;
        repeat (6) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_clear();
        checks++;
        if ({bottle_total, dozen_count, in_box, dozen_done, full} !== 32'd0) begin
            errors++;
            $display("FAIL clear_vs_accept got t=%0d d=%0d b=%0d required all 0", bottle_total, dozen_count, in_box);
        end
        repeat (4) @(negedge clk);
        sensor_raw = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (bottle_total !== 13'd0) begin
            errors++;
            $display("FAIL clear_lost got %0d required 0", bottle_total);
        end
        model_count();
        pulse(1'b0, 10, 10);
        drain("after_clear", 40);
        checks++;
        if (bottle_total !== 13'd1) begin
            errors++;
            $display("FAIL after_clear got %0d required 1", bottle_total);
        end
    endtask

    task automatic test_bounce_release();
        model_count();
        sensor_raw = 1'b1;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            sensor_raw = (i % 2 == 0) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        sensor_raw = 1'b0;
        repeat (15) @(negedge clk);
        drain("bounce", 40);
        checks++;
        if (bottle_total !== 13'd2) begin
            errors++;
            $display("FAIL bounce got %0d required 2", bottle_total);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_clean_pulses();
        test_saturation();
        test_gating_clear();
        test_bounce_release();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover pending=%0d required 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
